datamem_arbiter: RTL
====================

Name: datamem_arbiter

Overview:
- Two-requester arbiter in front of the single-port data memory: the CPU load/store stage (requester 0) and the debug/loader port (requester 1).
- Grants at most one access per cycle using round-robin priority.
- Drives the memory's address, write_enable, read_enable and write_data ports.
- Captures the memory's combinational read_data into a registered, per-requester response.

Parameters:
- ADDR_W, 16, address width; matches the data memory word address.
- DATA_W, 16, data word width.
- MAX_LOCK, 8, maximum consecutive locked grants to one requester (used only with the optional feature).

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- rN_valid  in  1  requester N (N=0,1) has an access pending
- rN_ready  out  1  requester N access accepted this cycle
- rN_we  in  1  1 = write, 0 = read
- rN_addr  in  ADDR_W  word address
- rN_wdata  in  DATA_W  write data
- rN_lock  in  1  request to keep the grant next cycle (optional feature only; ignored otherwise)
- rN_rsp_valid  out  1  read data valid for requester N
- rN_rsp_data  out  DATA_W  read data for requester N
- mem_address  out  ADDR_W  to memory address
- mem_write_enable  out  1  to memory write_enable
- mem_read_enable  out  1  to memory read_enable
- mem_write_data  out  DATA_W  to memory write_data
- mem_read_data  in  DATA_W  from memory read_data (combinational in address)

Behaviour:
- Reset (reset=0, asynchronous):
  - last_grant=1, so requester 0 wins the first tie.
  - state=ARB, lock_cnt=0.
  - rN_rsp_valid=0, rN_rsp_data=0.
  - rN_ready and mem enables forced 0 while reset is low.
  - A read accepted in the cycle reset asserts is dropped: no response.
- Grant (combinational, state ARB):
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant; mem_read_enable=mem_write_enable=0; mem_address and mem_write_data hold 0.
- Handshake:
  - rG_ready=1 for the granted requester in the same cycle; the access completes on that posedge.
  - A requester must hold valid/we/addr/wdata stable until it sees ready.
  - Ungranted requesters see ready=0.
- Memory drive (same cycle as grant):
  - mem_address=rG_addr.
  - mem_write_enable=rG_valid&rG_we.
  - mem_read_enable=rG_valid&~rG_we.
  - mem_write_data=rG_wdata.
- Read response:
  - On the accepting posedge, register mem_read_data into rG_rsp_data and set rG_rsp_valid=1.
  - Latency: response visible exactly 1 cycle after the ready cycle; valid lasts 1 cycle.
  - No backpressure on responses.
  - rN_rsp_data holds its last value when rsp_valid=0.
- Writes produce no response. The memory updates on the accepting posedge.
- last_grant updates to G on every accepted access. It is unchanged on idle cycles.
- Ordering:
  - Accesses complete in grant order.
  - Requester 1 writing A in cycle t followed by requester 0 reading A in cycle t+1 returns the new data.
  - Back-to-back accesses every cycle are supported; throughput is 1 access per cycle.
- State machine states:
  - ARB (normal).
  - LOCKED (optional feature only; never entered without the macro).

Optional Feature:
- Macro: DATAMEM_ARB_LOCK_EN.
- Defined:
  - An accepted access with rG_lock=1 moves ARB->LOCKED, owner=G, lock_cnt=1.
  - In LOCKED, only the owner can be granted; the other requester's ready stays 0.
  - Each owner access increments lock_cnt.
  - Exit to ARB when any of these occurs:
    - an accepted owner access has lock=0;
    - owner valid=0 for one cycle;
    - lock_cnt reaches MAX_LOCK while the other requester is valid.
  - On exit, last_grant=owner, so the other requester wins the next tie.
  - Async reset returns to ARB.
- Not defined: rN_lock ports exist but are ignored; pure round-robin.

Test Plan:
- Reset low 3 cycles with both valid -> all ready=0, mem enables=0, rsp_valid=0. After release with both valid, requester 0 is granted first.
- r0 write addr 0x0010 data 0xBEEF, next cycle r0 read 0x0010 -> mem_write_enable=1 in cycle 1. r0_rsp_valid=1 with r0_rsp_data=0xBEEF in cycle 3.
- Both valid reads every cycle for 6 cycles (r0 addr 0x0001, r1 addr 0x0002) -> grants alternate 0,1,0,1,... Each requester gets 3 responses, 1 cycle after each ready.
- r1 write 0x0020=0x1234 in cycle t, r0 read 0x0020 in cycle t+1 -> r0_rsp_data=0x1234 at t+2.
- Reset asserted mid-burst, the same cycle r0 read is accepted -> no r0_rsp_valid after reset. last_grant returns to 1.
- With DATAMEM_ARB_LOCK_EN and MAX_LOCK=4, r0 lock=1 reads continuously, r1 valid -> r0 gets 4 grants, then r1 is granted. Without the macro, strict alternation.

Source files
------------

// File: rtl/datamem_arbiter.sv
// datamem_arbiter: round-robin arbiter placing two requesters on the single-port data memory.
// Optional grant locking is enabled by defining DATAMEM_ARB_LOCK_EN.
module datamem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_lock,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_lock,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);
  typedef enum logic {ARB, LOCKED} state_t;
  state_t state, state_n;
  logic last_grant, last_grant_n, owner, owner_n;
  logic gnt, g_valid, g_we, act, rd0, rd1;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  // gnt selects requester 1 when set; the tie goes to whoever was not served last
  assign gnt = (state == LOCKED) ? owner
             : (r0_valid & r1_valid) ? ~last_grant
             : ~r0_valid & r1_valid;
  assign g_valid = gnt ? r1_valid : r0_valid;
  assign g_we    = gnt ? r1_we    : r0_we;
  assign g_addr  = gnt ? r1_addr  : r0_addr;
  assign g_wdata = gnt ? r1_wdata : r0_wdata;
  assign act     = reset & g_valid;
  assign r0_ready         = act & ~gnt;
  assign r1_ready         = act & gnt;
  assign mem_address      = act ? g_addr : '0;
  assign mem_write_data   = act ? g_wdata : '0;
  assign mem_write_enable = act & g_we;
  assign mem_read_enable  = act & ~g_we;
  assign rd0 = r0_ready & ~g_we;
  assign rd1 = r1_ready & ~g_we;
  assign last_grant_n = act ? gnt : last_grant;
`ifdef DATAMEM_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] lock_cnt, lock_cnt_n, cnt_inc;
  logic g_lock, other_valid, exit_lock;
  assign g_lock      = gnt ? r1_lock : r0_lock;
  assign other_valid = owner ? r0_valid : r1_valid;
  assign cnt_inc     = (lock_cnt == CW'(MAX_LOCK)) ? lock_cnt : lock_cnt + 1'b1;
  assign exit_lock   = ~g_valid | ~g_lock | ((cnt_inc == CW'(MAX_LOCK)) & other_valid);
  // last_grant already equals owner throughout a lock, so the other side wins the next tie
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    lock_cnt_n = lock_cnt;
    if (state == ARB && act && g_lock) begin
      state_n    = LOCKED;
      owner_n    = gnt;
      lock_cnt_n = CW'(1);
    end else if (state == LOCKED) begin
      state_n    = exit_lock ? ARB : LOCKED;
      lock_cnt_n = exit_lock ? '0 : cnt_inc;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) lock_cnt <= '0;
    else        lock_cnt <= lock_cnt_n;
`else
  logic unused_lock;
  assign unused_lock = r0_lock ^ r1_lock;
  assign state_n     = ARB;
  assign owner_n     = owner;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= ARB;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r0_rsp_data  <= '0;
      r1_rsp_data  <= '0;
    end else begin
      state        <= state_n;
      last_grant   <= last_grant_n;
      owner        <= owner_n;
      r0_rsp_valid <= rd0;
      r1_rsp_valid <= rd1;
      if (rd0) r0_rsp_data <= mem_read_data;
      if (rd1) r1_rsp_data <= mem_read_data;
    end
endmodule
